// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and the frame checksum helper for the
// framed UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [3:0] REG_CH_EN = 4'h0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_CMD,
    RX_DATA,
    RX_CHK
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } tx_state_e;

  // Checksum = CMD plus the low nbytes payload bytes, modulo 256.
  function automatic logic [7:0] frame_sum(input logic [7:0]  cmd,
                                           input logic [31:0] payload,
                                           input int          nbytes);
    logic [7:0] s;
    s = cmd;
    for (int i = 0; i < 4; i++) begin
      if (i < nbytes) s = s + payload[8*i +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Two-byte response sender. Buffers one ACK/NAK response and hands it byte by
// byte to the UART transmitter, pacing on the transmitter's busy flag.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       resp_push,
  input  logic [7:0] resp_b0,
  input  logic [7:0] resp_b1,
  input  logic       tx_busy,
  output logic       tx_req,
  output logic [7:0] tx_data,
  output logic       resp_busy
);

  tx_state_e  state_q, state_d;
  logic [7:0] buf0_q, buf0_d;
  logic [7:0] buf1_q, buf1_d;
  logic [1:0] sent_q, sent_d;
  logic       wb_cnt_q, wb_cnt_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Next state: a push is only taken in IDLE, so a response already in
  // flight can never be overwritten by a later frame.
  always_comb begin
    state_d   = state_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    sent_d    = sent_q;
    wb_cnt_d  = wb_cnt_q;
    tx_req_d  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (resp_push) begin
          buf0_d  = resp_b0;
          buf1_d  = resp_b1;
          sent_d  = 2'd0;
          state_d = TX_WAIT_IDLE;
        end
      end
      TX_REQ: begin
        wb_cnt_d = 1'b0;
        state_d  = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        // Give the transmitter two cycles to raise busy, then move on anyway.
        if (tx_busy || wb_cnt_q) state_d = TX_WAIT_IDLE;
        else                     wb_cnt_d = 1'b1;
      end
      TX_WAIT_IDLE: begin
        if (!tx_busy) begin
          if (sent_q == 2'd2) begin
            state_d = TX_IDLE;
          end else begin
            state_d   = TX_REQ;
            tx_req_d  = 1'b1;
            tx_data_d = (sent_q == 2'd0) ? buf0_q : buf1_q;
            sent_d    = sent_q + 2'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= TX_IDLE;
      buf0_q    <= '0;
      buf1_q    <= '0;
      sent_q    <= '0;
      wb_cnt_q  <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      sent_q    <= sent_d;
      wb_cnt_q  <= wb_cnt_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;
  assign resp_busy = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_cmd_frame.sv
// Framed UART command parser: HDR, CMD, payload (MSB first), CHK.
// Valid frames issue a one-cycle register-write strobe and are ACKed;
// bad frames bump a saturating error count and are NAKed.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_frame
  import uart_cmd_pkg::*;
#(
  parameter  int         CH_NUM      = 4,
  parameter  int         DATA_BYTES  = 2,
  parameter  logic [7:0] HDR_BYTE    = 8'hA5,
  parameter  int         TIMEOUT_CYC = 4340,
  localparam int         CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int         PW          = 8 * DATA_BYTES
)(
  input  logic            I_clk,
  input  logic            I_uart_rstn,
  input  logic [7:0]      I_rx_data,
  input  logic            I_rx_valid,
  output logic            O_tx_req,
  output logic [7:0]      O_tx_data,
  input  logic            I_tx_busy,
  output logic            O_cmd_valid,
  output logic [CH_W-1:0] O_cmd_ch,
  output logic [3:0]      O_cmd_reg,
  output logic [PW-1:0]   O_cmd_data,
  output logic [CH_NUM-1:0] O_ch_en,
  output logic [7:0]      O_err_cnt
);

  rx_state_e        rx_state_q, rx_state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [PW-1:0]    payload_q, payload_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CH_W-1:0]  cmd_ch_q, cmd_ch_d;
  logic [3:0]       cmd_reg_q, cmd_reg_d;
  logic [PW-1:0]    cmd_data_q, cmd_data_d;
  logic [CH_NUM-1:0] ch_en_q, ch_en_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             frame_done, frame_good, chk_ok, ch_ok;
  logic             to_expire;
  logic             resp_push, resp_busy;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle-gap counter inside a frame; an arriving byte always beats expiry.
  always_comb begin
    to_expire = (rx_state_q != RX_IDLE) && !I_rx_valid &&
                (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    to_cnt_d  = (I_rx_valid || rx_state_q == RX_IDLE || to_expire) ? '0 : to_cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge I_clk) begin
    if (!I_uart_rstn) to_cnt_q <= '0;
    else              to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expire = 1'b0;
`endif

  // Frame verdict is taken on the CHK byte itself, so every effect lands one cycle later.
  always_comb begin
    frame_done = (rx_state_q == RX_CHK) && I_rx_valid;
    chk_ok     = (frame_sum(cmd_q, 32'(payload_q), DATA_BYTES) == I_rx_data);
    ch_ok      = (int'(cmd_q[7:4]) < CH_NUM);
    frame_good = frame_done && chk_ok && ch_ok;
    resp_push  = frame_done && !resp_busy;
  end

  // Receive FSM next state plus command/enable/error updates.
  always_comb begin
    rx_state_d  = rx_state_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_d       = cmd_q;
    payload_d   = payload_q;
    cmd_valid_d = frame_good;
    cmd_ch_d    = cmd_ch_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    ch_en_d     = ch_en_q;
    err_cnt_d   = err_cnt_q;

    case (rx_state_q)
      RX_IDLE: if (I_rx_valid && I_rx_data == HDR_BYTE) rx_state_d = RX_CMD;
      RX_CMD: begin
        if (I_rx_valid) begin
          cmd_d      = I_rx_data;
          byte_cnt_d = 2'd0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (I_rx_valid) begin
          payload_d      = payload_q << 8;
          payload_d[7:0] = I_rx_data;
          if (byte_cnt_q == 2'(DATA_BYTES - 1)) rx_state_d = RX_CHK;
          else                                  byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      RX_CHK: if (I_rx_valid) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase

    if (to_expire) rx_state_d = RX_IDLE;

    if (frame_good) begin
      cmd_ch_d   = cmd_q[4 +: CH_W];
      cmd_reg_d  = cmd_q[3:0];
      cmd_data_d = payload_q;
      for (int i = 0; i < CH_NUM; i++) begin
        if (cmd_q[3:0] == REG_CH_EN && int'(cmd_q[7:4]) == i) ch_en_d[i] = payload_q[0];
      end
    end

    if (((frame_done && !frame_good) || to_expire) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  // Receive-side registers.
  always_ff @(posedge I_clk) begin
    if (!I_uart_rstn) begin
      rx_state_q  <= RX_IDLE;
      byte_cnt_q  <= '0;
      cmd_q       <= '0;
      payload_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      ch_en_q     <= '0;
      err_cnt_q   <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_q       <= cmd_d;
      payload_q   <= payload_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      ch_en_q     <= ch_en_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  uart_resp_tx u_resp_tx (
    .clk       (I_clk),
    .rstn      (I_uart_rstn),
    .resp_push (resp_push),
    .resp_b0   (frame_good ? ACK_BYTE : NAK_BYTE),
    .resp_b1   (cmd_q),
    .tx_busy   (I_tx_busy),
    .tx_req    (O_tx_req),
    .tx_data   (O_tx_data),
    .resp_busy (resp_busy)
  );

  assign O_cmd_valid = cmd_valid_q;
  assign O_cmd_ch    = cmd_ch_q;
  assign O_cmd_reg   = cmd_reg_q;
  assign O_cmd_data  = cmd_data_q;
  assign O_ch_en     = ch_en_q;
  assign O_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_frame.sv
// Scoreboard bench for uart_cmd_frame: stimulus pushes expected strobes and
// response bytes, independent monitors pop and compare them.
module tb_uart_cmd_frame;

  localparam int         CH_NUM      = 4;
  localparam int         DATA_BYTES  = 2;
  localparam int         TIMEOUT_CYC = 4340;
  localparam logic [7:0] HDR         = 8'hA5;
  localparam int         PW          = 8 * DATA_BYTES;
  localparam int         CH_W        = 2;

  logic              I_clk;
  logic              I_uart_rstn;
  logic [7:0]        I_rx_data;
  logic              I_rx_valid;
  logic              O_tx_req;
  logic [7:0]        O_tx_data;
  logic              I_tx_busy;
  logic              O_cmd_valid;
  logic [CH_W-1:0]   O_cmd_ch;
  logic [3:0]        O_cmd_reg;
  logic [PW-1:0]     O_cmd_data;
  logic [CH_NUM-1:0] O_ch_en;
  logic [7:0]        O_err_cnt;

  uart_cmd_frame #(
    .CH_NUM(CH_NUM), .DATA_BYTES(DATA_BYTES), .HDR_BYTE(HDR), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .I_clk(I_clk), .I_uart_rstn(I_uart_rstn), .I_rx_data(I_rx_data), .I_rx_valid(I_rx_valid),
    .O_tx_req(O_tx_req), .O_tx_data(O_tx_data), .I_tx_busy(I_tx_busy),
    .O_cmd_valid(O_cmd_valid), .O_cmd_ch(O_cmd_ch), .O_cmd_reg(O_cmd_reg),
    .O_cmd_data(O_cmd_data), .O_ch_en(O_ch_en), .O_err_cnt(O_err_cnt)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [3:0]        ch;
    logic [3:0]        rg;
    logic [PW-1:0]     data;
    logic [CH_NUM-1:0] ch_en;
    time               t;
  } cmd_exp_t;

  cmd_exp_t          cmd_q[$];
  logic [7:0]        tx_q[$];
  int                total = 0;
  int                bad = 0;
  logic [CH_NUM-1:0] m_ch_en;
  int                m_err;
  int                busy_cnt;
  logic              long_arm;
  cmd_exp_t          mon_e;
  logic [7:0]        mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural UART transmitter: busy for 12 cycles per byte, or 3000 when armed.
  assign I_tx_busy = (busy_cnt != 0);
  always @(posedge I_clk) begin
    if (!I_uart_rstn)      busy_cnt <= 0;
    else if (O_tx_req)     busy_cnt <= long_arm ? 3000 : 12;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Strobe monitor.
  always @(negedge I_clk) begin
    if (I_uart_rstn && O_cmd_valid) begin
      chk("strobe_expected", 32'(cmd_q.size() != 0), 1);
      if (cmd_q.size() != 0) begin
        mon_e = cmd_q.pop_front();
        chk("strobe_time", 32'($time - mon_e.t), 10);
        chk("cmd_ch", 32'(O_cmd_ch), 32'(mon_e.ch));
        chk("cmd_reg", 32'(O_cmd_reg), 32'(mon_e.rg));
        chk("cmd_data", 32'(O_cmd_data), 32'(mon_e.data));
        chk("strobe_ch_en", 32'(O_ch_en), 32'(mon_e.ch_en));
      end
    end
  end

  // Response byte monitor.
  always @(negedge I_clk) begin
    if (I_uart_rstn && O_tx_req) begin
      chk("tx_req_while_busy", 32'(I_tx_busy), 0);
      chk("tx_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) begin
        mon_b = tx_q.pop_front();
        chk("tx_data", 32'(O_tx_data), 32'(mon_b));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge I_clk);
    I_rx_data  = b;
    I_rx_valid = 1'b1;
    repeat (gap) begin
      @(negedge I_clk);
      I_rx_valid = 1'b0;
    end
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  // Sends one frame and records what the design must do with it.
  task automatic send_frame(input logic [7:0] cmd, input logic [PW-1:0] pl, input logic [7:0] ck,
                            input int gap, input int last_gap, input bit drop, input int stall);
    logic [7:0] s;
    bit         good;
    bit         aborted;
    cmd_exp_t   e;
    s = cmd;
    for (int i = 0; i < DATA_BYTES; i++) s = s + pl[8*i +: 8];
    good    = (s == ck) && (int'(cmd[7:4]) < CH_NUM);
    aborted = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    aborted = (stall >= TIMEOUT_CYC);
`endif
    send_byte(HDR, $urandom_range(0, gap));
    send_byte(cmd, (stall > 0) ? stall : $urandom_range(0, gap));
    for (int i = DATA_BYTES - 1; i >= 0; i--) send_byte(pl[8*i +: 8], $urandom_range(0, gap));
    @(negedge I_clk);
    I_rx_data  = ck;
    I_rx_valid = 1'b1;
    if (aborted) begin
      bump_err();
    end else if (good) begin
      if (cmd[3:0] == 4'h0) m_ch_en[cmd[7:4]] = pl[0];
      e.ch = cmd[7:4]; e.rg = cmd[3:0]; e.data = pl; e.ch_en = m_ch_en; e.t = $time;
      cmd_q.push_back(e);
      if (!drop) begin tx_q.push_back(8'h06); tx_q.push_back(cmd); end
    end else begin
      bump_err();
      if (!drop) begin tx_q.push_back(8'h15); tx_q.push_back(cmd); end
    end
    repeat (last_gap) begin
      @(negedge I_clk);
      I_rx_valid = 1'b0;
    end
  endtask

  // Waits for the response to drain, then checks everything outstanding.
  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || I_tx_busy || O_tx_req) && n < budget) begin
      @(negedge I_clk);
      n++;
    end
    repeat (6) @(negedge I_clk);
    chk("settle_in_time", 32'(n < budget), 1);
    chk("strobe_missing", 32'(cmd_q.size()), 0);
    chk("tx_missing", 32'(tx_q.size()), 0);
    chk("err_cnt", 32'(O_err_cnt), 32'(m_err));
    chk("ch_en", 32'(O_ch_en), 32'(m_ch_en));
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_req", 32'(O_tx_req), 0);
    chk("rst_tx_data", 32'(O_tx_data), 0);
    chk("rst_cmd_valid", 32'(O_cmd_valid), 0);
    chk("rst_cmd_ch", 32'(O_cmd_ch), 0);
    chk("rst_cmd_reg", 32'(O_cmd_reg), 0);
    chk("rst_cmd_data", 32'(O_cmd_data), 0);
    chk("rst_ch_en", 32'(O_ch_en), 0);
    chk("rst_err_cnt", 32'(O_err_cnt), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            nn;
    logic [7:0]    nb, rc, rk, rs;
    logic [PW-1:0] rp;

    I_uart_rstn = 1'b0;
    I_rx_data   = 8'h00;
    I_rx_valid  = 1'b0;
    long_arm    = 1'b0;
    m_ch_en     = '0;
    m_err       = 0;
    repeat (3) @(negedge I_clk);
    check_reset_outputs();
    I_uart_rstn = 1'b1;
    repeat (2) @(negedge I_clk);

    // Directed frames.
    send_frame(8'h12, 16'h0140, 8'h53, 2, 1, 0, 0); settle(200);
    send_frame(8'h30, 16'h0001, 8'h31, 2, 1, 0, 0); settle(200);
    send_frame(8'h30, 16'h0000, 8'h30, 2, 1, 0, 0); settle(200);
    send_frame(8'h12, 16'h0140, 8'h54, 2, 1, 0, 0); settle(200);
    send_frame(8'h52, 16'h0000, 8'h52, 2, 1, 0, 0); settle(200);

    // Leading noise.
    send_byte(8'h00, 1); send_byte(8'hFF, 2); send_byte(8'h7E, 0);
    send_frame(8'h21, 16'h0203, 8'h26, 1, 1, 0, 0); settle(200);

    // Long busy on the first response byte; a back-to-back frame gets no response.
    long_arm = 1'b1;
    send_frame(8'h21, 16'h0203, 8'h26, 0, 0, 0, 0);
    send_frame(8'h13, 16'h0001, 8'h14, 0, 1, 1, 0);
    n = 0;
    while (!I_tx_busy && n < 50) begin @(negedge I_clk); n++; end
    chk("long_busy_seen", 32'(I_tx_busy), 1);
    long_arm = 1'b0;
    settle(4000);

    // Stalled frame: times out with the feature, completes without it.
    send_frame(8'h12, 16'h0140, 8'h53, 0, 1, 0, 4400); settle(200);
    send_frame(8'h30, 16'h0001, 8'h31, 1, 1, 0, 0); settle(200);

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      nn = $urandom_range(0, 2);
      for (int j = 0; j < nn; j++) begin
        nb = 8'($urandom);
        if (nb == HDR) nb = 8'h00;
        send_byte(nb, $urandom_range(0, 3));
      end
      rc = {4'($urandom_range(0, 5)), ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15))};
      rp = PW'($urandom);
      rs = rc;
      for (int i = 0; i < DATA_BYTES; i++) rs = rs + rp[8*i +: 8];
      rk = rs;
      if ($urandom_range(0, 3) == 0) rk = rs + 8'($urandom_range(1, 255));
      send_frame(rc, rp, rk, 3, 1, 0, 0);
      settle(200);
    end

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      send_frame(8'h12, 16'h0140, 8'h00, 0, 1, 0, 0);
      settle(200);
    end
    chk("err_saturated", 32'(O_err_cnt), 255);

    // Reset in the middle of a frame discards it.
    send_byte(HDR, 1); send_byte(8'h12, 1); send_byte(8'h01, 1);
    @(negedge I_clk);
    I_uart_rstn = 1'b0;
    m_err   = 0;
    m_ch_en = '0;
    cmd_q.delete();
    tx_q.delete();
    repeat (2) @(negedge I_clk);
    check_reset_outputs();
    I_uart_rstn = 1'b1;
    send_byte(8'h40, 1); send_byte(8'h53, 2);
    settle(200);
    send_frame(8'h30, 16'h0001, 8'h31, 1, 1, 0, 0); settle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
